// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-master single-port RAM arbiter with owner FSM and read tag pipeline
// Define ARB_FAIR_EN to compile in BURST_MAX burst limiting; default build is pure m0 priority.
module ram_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic        read_clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [13:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_gnt,
  output logic [15:0] m0_rdata,
  output logic        m0_rvalid,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [13:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_gnt,
  output logic [15:0] m1_rdata,
  output logic        m1_rvalid,
  output logic        ram_en,
  output logic        ram_we,
  output logic [13:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic [1:0]  owner
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_burst_max
    $error("ram_arbiter: BURST_MAX must be in 1..15");
  end

  logic [1:0]  state;
  logic        pick_m1;
  logic        grant_any;
  logic        sel_we;
  logic [13:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        tag1_valid, tag1_read, tag1_id;
  logic        tag2_valid, tag2_read, tag2_id;

`ifdef ARB_FAIR_EN
  logic [3:0] burst_cnt;
  logic       burst_full;

  assign burst_full = (burst_cnt >= 4'(BURST_MAX));

  // Contention winner: stay with the owner until its burst is used up, then hand over.
  always_comb begin
    pick_m1 = 1'b0;
    case (state)
      ST_OWN0: pick_m1 = burst_full;
      ST_OWN1: pick_m1 = !burst_full;
      default: pick_m1 = 1'b0;
    endcase
  end

  always_ff @(posedge read_clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= 4'd0;
    end else if (!grant_any) begin
      burst_cnt <= 4'd0;
    end else if ((state == ST_OWN0 && m0_gnt) || (state == ST_OWN1 && m1_gnt)) begin
      if (burst_cnt != 4'hF) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
    end else begin
      burst_cnt <= 4'd1;
    end
  end
`else
  assign pick_m1 = 1'b0;
`endif

  assign m0_gnt    = !reset && m0_req && !(m1_req && pick_m1);
  assign m1_gnt    = !reset && m1_req && (!m0_req || pick_m1);
  assign grant_any = m0_gnt || m1_gnt;

  assign sel_we    = m1_gnt ? m1_we    : m0_we;
  assign sel_addr  = m1_gnt ? m1_addr  : m0_addr;
  assign sel_wdata = m1_gnt ? m1_wdata : m0_wdata;

  always_ff @(posedge read_clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= 14'd0;
      ram_wdata  <= 16'd0;
      tag1_valid <= 1'b0;
      tag1_read  <= 1'b0;
      tag1_id    <= 1'b0;
      tag2_valid <= 1'b0;
      tag2_read  <= 1'b0;
      tag2_id    <= 1'b0;
    end else begin
      ram_en <= grant_any;
      if (grant_any) begin
        ram_we    <= sel_we;
        ram_addr  <= sel_addr;
        ram_wdata <= sel_wdata;
      end
      if (!grant_any) begin
        state <= ST_IDLE;
      end else if (m1_gnt) begin
        state <= ST_OWN1;
      end else begin
        state <= ST_OWN0;
      end
      // Stage 1 lines up with the RAM command, stage 2 with the returning read data.
      tag1_valid <= grant_any;
      tag1_read  <= !sel_we;
      tag1_id    <= m1_gnt;
      tag2_valid <= tag1_valid;
      tag2_read  <= tag1_read;
      tag2_id    <= tag1_id;
    end
  end

  assign owner     = state;
  assign m0_rvalid = tag2_valid && tag2_read && !tag2_id;
  assign m1_rvalid = tag2_valid && tag2_read && tag2_id;
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a RAM model and a grant/read scoreboard
`timescale 1ns/1ps
module tb_ram_arbiter;
  localparam int BURST_MAX = 4;

  logic        read_clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [13:0] m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata;
  logic        ram_en, ram_we;
  logic [13:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata;
  logic [1:0]  owner;

  int tests_run = 0;
  int tests_failed = 0;

  ram_arbiter #(.BURST_MAX(BURST_MAX)) dut (
    .read_clk(read_clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .owner(owner)
  );

  always #5 read_clk = ~read_clk;

  // Synchronous RAM: read data appears the cycle after the read command.
  logic [15:0] ram_mem [0:16383];
  always @(posedge read_clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] = ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Reference model: owner as 0/1/2, run = consecutive grants to the same master.
  typedef struct { int due; int id; logic [15:0] data; } rd_t;
  rd_t         rdq[$];
  logic [15:0] shadow [0:16383];
  int          cyc = 0;
  int          m_owner = 0;
  int          m_run = 0;
  logic        m_en = 1'b0, m_we = 1'b0;
  logic [13:0] m_addr = '0;
  logic [15:0] m_wd = '0;

  logic        x_g0, x_g1, x_rv0, x_rv1, x_en, x_we;
  logic [15:0] x_rd, x_wd;
  logic [13:0] x_addr;
  logic [1:0]  x_owner;
  logic        s_g0, s_g1, s_rv0, s_rv1, s_en, s_we;
  logic [15:0] s_rd0, s_rd1, s_wd;
  logic [13:0] s_addr;
  logic [1:0]  s_owner;

  function automatic logic pick_m1();
`ifdef ARB_FAIR_EN
    if (m_owner == 1) return (m_run >= BURST_MAX);
    if (m_owner == 2) return (m_run < BURST_MAX);
`endif
    return 1'b0;
  endfunction

  task automatic drive(input logic r0, input logic w0, input logic [13:0] a0, input logic [15:0] d0,
                       input logic r1, input logic w1, input logic [13:0] a1, input logic [15:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 14'h0, 16'h0, 1'b0, 1'b0, 14'h0, 16'h0);
  endtask

  // One clock cycle: predict, snapshot DUT mid-cycle, advance the model, step to next edge.
  task automatic cycle();
    int          id;
    logic        we;
    logic [13:0] a;
    logic [15:0] d;
    #2;
    x_g0 = 1'b0; x_g1 = 1'b0;
    if (m0_req && m1_req) begin
      if (pick_m1()) x_g1 = 1'b1; else x_g0 = 1'b1;
    end else begin
      x_g0 = m0_req; x_g1 = m1_req;
    end
    x_rv0 = 1'b0; x_rv1 = 1'b0; x_rd = '0;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      if (rdq[0].id == 0) x_rv0 = 1'b1; else x_rv1 = 1'b1;
      x_rd = rdq[0].data;
      void'(rdq.pop_front());
    end
    x_en = m_en; x_we = m_we; x_addr = m_addr; x_wd = m_wd; x_owner = 2'(m_owner);
    s_g0 = m0_gnt; s_g1 = m1_gnt; s_rv0 = m0_rvalid; s_rv1 = m1_rvalid;
    s_rd0 = m0_rdata; s_rd1 = m1_rdata; s_en = ram_en; s_we = ram_we;
    s_addr = ram_addr; s_wd = ram_wdata; s_owner = owner;
    if (x_g0 || x_g1) begin
      id = x_g1 ? 1 : 0;
      we = id == 1 ? m1_we : m0_we;
      a  = id == 1 ? m1_addr : m0_addr;
      d  = id == 1 ? m1_wdata : m0_wdata;
      m_en = 1'b1; m_we = we; m_addr = a; m_wd = d;
      if (we) shadow[a] = d;
      else    rdq.push_back('{due: cyc + 2, id: id, data: shadow[a]});
      if (m_owner == id + 1) m_run++; else m_run = 1;
      m_owner = id + 1;
    end else begin
      m_en = 1'b0; m_owner = 0; m_run = 0;
    end
    @(posedge read_clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    drive_idle();
    repeat (n) cycle();
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    drive_idle();
    rdq.delete();
    m_owner = 0; m_run = 0; m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0;
    repeat (n) @(posedge read_clk);
    #1;
    reset = 1'b0;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 14'h3, 16'h1234, 1'b1, 1'b0, 14'h4, 16'h0);
    @(posedge read_clk);
    #3;
    tests_run++; if ({m0_gnt, m1_gnt} !== 2'b00) begin tests_failed++; $display("FAIL rst_gnt: got %b required 00", {m0_gnt, m1_gnt}); end
    tests_run++; if ({ram_en, ram_we, m0_rvalid, m1_rvalid} !== 4'b0) begin tests_failed++; $display("FAIL rst_strobes: got %b required 0000", {ram_en, ram_we, m0_rvalid, m1_rvalid}); end
    tests_run++; if ({ram_addr, ram_wdata} !== 30'h0) begin tests_failed++; $display("FAIL rst_ram_bus: got %h required 0", {ram_addr, ram_wdata}); end
    tests_run++; if (owner !== 2'b00) begin tests_failed++; $display("FAIL rst_owner: got %b required 00", owner); end
    apply_reset(1);
    drive(1'b1, 1'b1, 14'h5, 16'h5A5A, 1'b0, 1'b0, 14'h0, 16'h0);
    cycle();
    tests_run++; if (s_g0 !== 1'b1) begin tests_failed++; $display("FAIL first_gnt_after_reset: got %b required 1", s_g0); end
    idle(3);
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b1, 14'h0010, 16'hBEEF, 1'b0, 1'b0, 14'h0, 16'h0);
    cycle();
    tests_run++; if (s_g0 !== 1'b1) begin tests_failed++; $display("FAIL wr_gnt0: got %b required 1", s_g0); end
    drive(1'b0, 1'b0, 14'h0, 16'h0, 1'b1, 1'b0, 14'h0010, 16'h0);
    cycle();
    tests_run++; if ({s_g0, s_g1} !== 2'b01) begin tests_failed++; $display("FAIL rd_gnt1: got %b required 01", {s_g0, s_g1}); end
    tests_run++; if ({s_en, s_we, s_addr, s_wd} !== {1'b1, 1'b1, 14'h0010, 16'hBEEF}) begin tests_failed++; $display("FAIL wr_ram_cmd: got %h required %h", {s_en, s_we, s_addr, s_wd}, {1'b1, 1'b1, 14'h0010, 16'hBEEF}); end
    drive_idle();
    cycle();
    tests_run++; if (s_rv1 !== 1'b0) begin tests_failed++; $display("FAIL rd_rvalid_early: got %b required 0", s_rv1); end
    cycle();
    tests_run++; if ({s_rv0, s_rv1} !== 2'b01) begin tests_failed++; $display("FAIL rd_rvalid: got %b required 01", {s_rv0, s_rv1}); end
    tests_run++; if (s_rd1 !== 16'hBEEF) begin tests_failed++; $display("FAIL rd_data: got %h required beef", s_rd1); end
    cycle();
    tests_run++; if (s_rv1 !== 1'b0) begin tests_failed++; $display("FAIL rd_rvalid_late: got %b required 0", s_rv1); end
    idle(2);
  endtask

  task automatic test_contention();
    idle(1);
    drive(1'b1, 1'b1, 14'h20, 16'h1111, 1'b1, 1'b1, 14'h21, 16'h2222);
    cycle();
    tests_run++; if ({s_g0, s_g1} !== 2'b10) begin tests_failed++; $display("FAIL cont_first: got %b required 10", {s_g0, s_g1}); end
    drive(1'b0, 1'b0, 14'h0, 16'h0, 1'b1, 1'b1, 14'h21, 16'h2222);
    cycle();
    tests_run++; if ({s_g0, s_g1} !== 2'b01) begin tests_failed++; $display("FAIL cont_second: got %b required 01", {s_g0, s_g1}); end
    idle(3);
  endtask

  task automatic test_burst();
    logic want_m1;
    idle(1);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, 14'(i), 16'(i), 1'b1, 1'b1, 14'(100 + i), 16'(i));
      cycle();
`ifdef ARB_FAIR_EN
      want_m1 = ((i / BURST_MAX) % 2) == 1;
`else
      want_m1 = 1'b0;
`endif
      tests_run++; if ({s_g0, s_g1} !== {!want_m1, want_m1}) begin tests_failed++; $display("FAIL burst_pattern[%0d]: got %b required %b", i, {s_g0, s_g1}, {!want_m1, want_m1}); end
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [15:0] d [3];
    for (int i = 0; i < 3; i++) begin
      d[i] = 16'($urandom);
      drive(1'b1, 1'b1, 14'(i + 1), d[i], 1'b0, 1'b0, 14'h0, 16'h0);
      cycle();
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, 1'b0, 14'(i + 1), 16'h0, 1'b0, 1'b0, 14'h0, 16'h0);
      else       drive_idle();
      cycle();
      if (i >= 2) begin
        tests_run++; if ({s_rv0, s_rv1} !== 2'b10) begin tests_failed++; $display("FAIL b2b_rvalid[%0d]: got %b required 10", i, {s_rv0, s_rv1}); end
        tests_run++; if (s_rd0 !== d[i - 2]) begin tests_failed++; $display("FAIL b2b_data[%0d]: got %h required %h", i, s_rd0, d[i - 2]); end
      end
    end
    idle(2);
  endtask

  task automatic test_idle();
    drive(1'b0, 1'b0, 14'h0, 16'h0, 1'b1, 1'b1, 14'h30, 16'h3333);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      cycle();
      tests_run++; if ({s_g0, s_g1} !== 2'b00) begin tests_failed++; $display("FAIL idle_gnt[%0d]: got %b required 00", i, {s_g0, s_g1}); end
      if (i >= 1) begin
        tests_run++; if ({s_en, s_owner} !== 3'b000) begin tests_failed++; $display("FAIL idle_en_owner[%0d]: got %b required 000", i, {s_en, s_owner}); end
      end
    end
  endtask

  task automatic test_random();
    logic        p_req [2];
    logic        p_we  [2];
    logic [13:0] p_a   [2];
    logic [15:0] p_d   [2];
    for (int a = 0; a < 8; a++) begin
      drive(1'b1, 1'b1, 14'(a), 16'($urandom), 1'b0, 1'b0, 14'h0, 16'h0);
      cycle();
    end
    p_req[0] = 1'b0; p_req[1] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!p_req[m] && $urandom_range(0, 3) != 0) begin
          p_req[m] = 1'b1;
          p_we[m]  = 1'($urandom_range(0, 1));
          p_a[m]   = 14'($urandom_range(0, 7));
          p_d[m]   = 16'($urandom);
        end
      end
      drive(p_req[0], p_we[0], p_a[0], p_d[0], p_req[1], p_we[1], p_a[1], p_d[1]);
      cycle();
      tests_run++; if ({s_g0, s_g1} !== {x_g0, x_g1}) begin tests_failed++; $display("FAIL rnd_gnt[%0d]: got %b required %b", i, {s_g0, s_g1}, {x_g0, x_g1}); end
      tests_run++; if ({s_rv0, s_rv1} !== {x_rv0, x_rv1}) begin tests_failed++; $display("FAIL rnd_rvalid[%0d]: got %b required %b", i, {s_rv0, s_rv1}, {x_rv0, x_rv1}); end
      if (x_rv0) begin
        tests_run++; if (s_rd0 !== x_rd) begin tests_failed++; $display("FAIL rnd_rdata0[%0d]: got %h required %h", i, s_rd0, x_rd); end
      end
      if (x_rv1) begin
        tests_run++; if (s_rd1 !== x_rd) begin tests_failed++; $display("FAIL rnd_rdata1[%0d]: got %h required %h", i, s_rd1, x_rd); end
      end
      tests_run++; if ({s_en, s_we, s_addr, s_wd} !== {x_en, x_we, x_addr, x_wd}) begin tests_failed++; $display("FAIL rnd_ram_cmd[%0d]: got %h required %h", i, {s_en, s_we, s_addr, s_wd}, {x_en, x_we, x_addr, x_wd}); end
      tests_run++; if (s_owner !== x_owner) begin tests_failed++; $display("FAIL rnd_owner[%0d]: got %b required %b", i, s_owner, x_owner); end
      if (x_g0) p_req[0] = 1'b0;
      if (x_g1) p_req[1] = 1'b0;
    end
    idle(3);
  endtask

  task automatic test_reset_mid_read();
    drive(1'b1, 1'b0, 14'h2, 16'h0, 1'b0, 1'b0, 14'h0, 16'h0);
    cycle();
    reset = 1'b1;
    drive(1'b1, 1'b0, 14'h2, 16'h0, 1'b1, 1'b0, 14'h3, 16'h0);
    #2;
    tests_run++; if ({m0_gnt, m1_gnt, ram_en, ram_we, m0_rvalid, m1_rvalid} !== 6'b0) begin tests_failed++; $display("FAIL midrst_strobes: got %b required 000000", {m0_gnt, m1_gnt, ram_en, ram_we, m0_rvalid, m1_rvalid}); end
    tests_run++; if ({ram_addr, ram_wdata, owner} !== 32'h0) begin tests_failed++; $display("FAIL midrst_regs: got %h required 0", {ram_addr, ram_wdata, owner}); end
    apply_reset(2);
    for (int i = 0; i < 4; i++) begin
      drive_idle();
      cycle();
      tests_run++; if ({s_rv0, s_rv1, s_owner} !== 4'b0000) begin tests_failed++; $display("FAIL midrst_after[%0d]: got %b required 0000", i, {s_rv0, s_rv1, s_owner}); end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_write_read();
    test_contention();
    test_burst();
    test_back_to_back();
    test_idle();
    test_random();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
